decode_regfile_pipe: RTL

- Parametrised successor decode stage with an integrated register file and a valid/ready pipeline register.
- Classifies MIPS R/I/J instructions and generates the control bundle (dest select, reg/mem write, branch/jump, illegal).
- Extends immediates to WIDTH and captures register operands alongside the instruction.
- Sits between fetch and execute; the writeback stage drives its write port.

---
 rtl/decode_regfile_pipe_if.sv | 49 ++++
 rtl/decode_regfile_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_regfile_pipe_if.sv
// Bundle of the fetch, execute and writeback signals around the decode stage.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface decode_regfile_pipe_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           insn;
    logic [31:0]           pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           pc_out;
    logic [31:0]           insn_out;
    logic [5:0]            opcode_out;
    logic [5:0]            func_out;
    logic [REG_ADDR_W-1:0] rs_out;
    logic [REG_ADDR_W-1:0] rt_out;
    logic [REG_ADDR_W-1:0] rd_out;
    logic [4:0]            sa_out;
    logic [REG_ADDR_W-1:0] dest_out;
    logic [WIDTH-1:0]      imm_out;
    logic [WIDTH-1:0]      rs_val_out;
    logic [WIDTH-1:0]      rt_val_out;
    logic [5:0]            alu_op_out;
    logic                  reg_write_out;
    logic                  mem_read_out;
    logic                  mem_write_out;
    logic                  branch_out;
    logic                  jump_out;
    logic                  illegal_out;
    logic                  we_regfile;
    logic [REG_ADDR_W-1:0] waddr_regfile;
    logic [WIDTH-1:0]      dval_regfile;

    modport slave (
        input  in_valid, insn, pc, out_ready, we_regfile, waddr_regfile, dval_regfile,
        output in_ready, out_valid, pc_out, insn_out, opcode_out, func_out, rs_out, rt_out,
               rd_out, sa_out, dest_out, imm_out, rs_val_out, rt_val_out, alu_op_out,
               reg_write_out, mem_read_out, mem_write_out, branch_out, jump_out, illegal_out
    );

    modport master (
        output in_valid, insn, pc, out_ready, we_regfile, waddr_regfile, dval_regfile,
        input  in_ready, out_valid, pc_out, insn_out, opcode_out, func_out, rs_out, rt_out,
               rd_out, sa_out, dest_out, imm_out, rs_val_out, rt_val_out, alu_op_out,
               reg_write_out, mem_read_out, mem_write_out, branch_out, jump_out, illegal_out
    );
endinterface

// File: rtl/decode_regfile_pipe.sv
// MIPS decode stage with integrated register file and a valid/ready output register.
// Define WB_BYPASS_EN to forward same-edge writeback data into captured/held operands.
module decode_regfile_pipe #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned INIT_INDEX = 1
) (
    input logic                  clock,
    input logic                  reset_n,
    decode_regfile_pipe_if.slave bus
);
    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           insn;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] dest;
        logic [WIDTH-1:0]      imm;
        logic [WIDTH-1:0]      rs_val;
        logic [WIDTH-1:0]      rt_val;
        logic [5:0]            alu_op;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  illegal;
    } entry_t;

    logic [WIDTH-1:0]      regs_q [NUM_REGS];
    entry_t                entry_q, entry_d, dec;
    logic                  out_valid_q, out_valid_d;
    logic                  capture;
    logic                  wr_en;
    logic [5:0]            opcode, func;
    logic [REG_ADDR_W-1:0] rs_idx, rt_idx, rd_idx;
    logic [WIDTH-1:0]      rs_rd, rt_rd;

    function automatic logic r_func_ok(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09, 6'h10, 6'h12,
            6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
            6'h26, 6'h27, 6'h2A, 6'h2B: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    assign opcode  = bus.insn[31:26];
    assign func    = bus.insn[5:0];
    assign rs_idx  = REG_ADDR_W'(bus.insn[25:21]);
    assign rt_idx  = REG_ADDR_W'(bus.insn[20:16]);
    assign rd_idx  = REG_ADDR_W'(bus.insn[15:11]);

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign capture      = bus.in_valid && bus.in_ready;
    assign wr_en        = bus.we_regfile && (bus.waddr_regfile != '0)
                          && (32'(bus.waddr_regfile) < NUM_REGS);

    // Out-of-range indices fall through the loop and read as zero.
    always_comb begin
        rs_rd = '0;
        rt_rd = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rs_idx == REG_ADDR_W'(i)) rs_rd = regs_q[i];
            if (rt_idx == REG_ADDR_W'(i)) rt_rd = regs_q[i];
        end
    end

    always_comb begin
        dec        = '0;
        dec.pc     = bus.pc;
        dec.insn   = bus.insn;
        dec.rs     = rs_idx;
        dec.rt     = rt_idx;
        dec.rd     = rd_idx;
        dec.alu_op = (opcode == 6'h00 || opcode == 6'h1C) ? func : opcode;
        case (opcode)
            6'h00: begin
                if (r_func_ok(func)) begin
                    dec.dest      = rd_idx;
                    dec.reg_write = !(func inside {[6'h18:6'h1B], 6'h08});
                    dec.jump      = (func == 6'h08) || (func == 6'h09);
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            6'h1C: begin
                if (func == 6'h02) begin
                    dec.dest      = rd_idx;
                    dec.reg_write = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h20, 6'h23, 6'h24: begin
                dec.dest      = rt_idx;
                dec.reg_write = 1'b1;
                dec.mem_read  = opcode inside {6'h20, 6'h23, 6'h24};
                dec.imm       = WIDTH'($signed(bus.insn[15:0]));
            end
            6'h0D, 6'h0E: begin
                dec.dest      = rt_idx;
                dec.reg_write = 1'b1;
                dec.imm       = WIDTH'(bus.insn[15:0]);
            end
            6'h0F: begin
                dec.dest      = rt_idx;
                dec.reg_write = 1'b1;
                dec.imm       = WIDTH'({bus.insn[15:0], 16'h0000});
            end
            6'h28, 6'h2B: begin
                dec.mem_write = 1'b1;
                dec.imm       = WIDTH'($signed(bus.insn[15:0]));
            end
            6'h04, 6'h05, 6'h07: begin
                dec.branch = 1'b1;
                dec.imm    = WIDTH'($signed({bus.insn[15:0], 2'b00}));
            end
            6'h02, 6'h03: begin
                dec.jump = 1'b1;
                dec.imm  = WIDTH'({bus.pc[31:28], bus.insn[25:0], 2'b00});
                if (opcode == 6'h03) begin
                    dec.dest      = REG_ADDR_W'(31);
                    dec.reg_write = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        // Writes to $0 are discarded, which makes the all-zero word a NOP.
        if (dec.dest == '0) dec.reg_write = 1'b0;
`ifdef WB_BYPASS_EN
        dec.rs_val = (wr_en && bus.waddr_regfile == rs_idx) ? bus.dval_regfile : rs_rd;
        dec.rt_val = (wr_en && bus.waddr_regfile == rt_idx) ? bus.dval_regfile : rt_rd;
`else
        dec.rs_val = rs_rd;
        dec.rt_val = rt_rd;
`endif
    end

    always_comb begin
        entry_d     = entry_q;
        out_valid_d = out_valid_q;
        if (capture) begin
            entry_d     = dec;
            out_valid_d = 1'b1;
        end else begin
            if (bus.out_ready) out_valid_d = 1'b0;
`ifdef WB_BYPASS_EN
            if (out_valid_q && wr_en) begin
                if (bus.waddr_regfile == entry_q.rs) entry_d.rs_val = bus.dval_regfile;
                if (bus.waddr_regfile == entry_q.rt) entry_d.rt_val = bus.dval_regfile;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            entry_q     <= entry_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (INIT_INDEX != 0) ? WIDTH'(unsigned'(i)) : '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_en && bus.waddr_regfile == REG_ADDR_W'(i)) regs_q[i] <= bus.dval_regfile;
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.pc_out        = entry_q.pc;
    assign bus.insn_out      = entry_q.insn;
    assign bus.opcode_out    = entry_q.insn[31:26];
    assign bus.func_out      = entry_q.insn[5:0];
    assign bus.sa_out        = entry_q.insn[10:6];
    assign bus.rs_out        = entry_q.rs;
    assign bus.rt_out        = entry_q.rt;
    assign bus.rd_out        = entry_q.rd;
    assign bus.dest_out      = entry_q.dest;
    assign bus.imm_out       = entry_q.imm;
    assign bus.rs_val_out    = entry_q.rs_val;
    assign bus.rt_val_out    = entry_q.rt_val;
    assign bus.alu_op_out    = entry_q.alu_op;
    assign bus.reg_write_out = entry_q.reg_write;
    assign bus.mem_read_out  = entry_q.mem_read;
    assign bus.mem_write_out = entry_q.mem_write;
    assign bus.branch_out    = entry_q.branch;
    assign bus.jump_out      = entry_q.jump;
    assign bus.illegal_out   = entry_q.illegal;
endmodule
